// File: rtl/fib_engine.sv
// fib_engine: computes f(N) of the weighted Fibonacci-style sequence
//   f(0)=f(1)=f(2)=1, f(n) = (n-1)*f(n-1) + (n-2)*f(n-2)
// with an iterative shift-add multiplier (one coefficient bit per cycle).
// A new computation starts on every release of the active-low reset.
module fib_engine #(
  parameter int WORDSIZE = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          n,
  output logic                ready,
  output logic [WORDSIZE-1:0] result
);

  localparam logic [2:0] ST_LOAD   = 3'd0;
  localparam logic [2:0] ST_MUL_A  = 3'd1;
  localparam logic [2:0] ST_MUL_B  = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [WORDSIZE-1:0] WORD_ZERO = {WORDSIZE{1'b0}};
  localparam logic [WORDSIZE-1:0] WORD_ONE  = {{(WORDSIZE-1){1'b0}}, 1'b1};

  // Registered state: a holds f(k-2), b holds f(k-1), acc builds f(k).
  logic [2:0]          state_r, state_s;
  logic [7:0]          arg_r, arg_s;
  logic [7:0]          k_r, k_s;
  logic [7:0]          coef_r, coef_s;
  logic [2:0]          cnt_r, cnt_s;
  logic [WORDSIZE-1:0] a_r, a_s;
  logic [WORDSIZE-1:0] b_r, b_s;
  logic [WORDSIZE-1:0] acc_r, acc_s;
  logic [WORDSIZE-1:0] mcand_r, mcand_s;
  logic [WORDSIZE-1:0] result_r, result_s;
  logic                ready_r, ready_s;
  logic [WORDSIZE-1:0] add_s;

  assign ready  = ready_r;
  assign result = result_r;

  // One shift-add step: add the multiplicand when the current coefficient LSB is set.
  always_comb begin
    if (coef_r[0]) begin
      add_s = acc_r + mcand_r;
    end else begin
      add_s = acc_r;
    end
  end

  // Controller and datapath next-state logic.
  always_comb begin
    state_s  = state_r;
    arg_s    = arg_r;
    k_s      = k_r;
    coef_s   = coef_r;
    cnt_s    = cnt_r;
    a_s      = a_r;
    b_s      = b_r;
    acc_s    = acc_r;
    mcand_s  = mcand_r;
    result_s = result_r;
    ready_s  = ready_r;
    case (state_r)
      ST_LOAD: begin
        arg_s = n;
        if (n <= 8'd2) begin
          // b already holds 1, which is the answer for N<=2
          state_s = ST_DONE;
        end else begin
          state_s = ST_MUL_A;
          coef_s  = k_r - 8'd1;
          mcand_s = b_r;
          acc_s   = WORD_ZERO;
          cnt_s   = 3'd0;
        end
      end
      ST_MUL_A: begin
        acc_s   = add_s;
        coef_s  = {1'b0, coef_r[7:1]};
        mcand_s = {mcand_r[WORDSIZE-2:0], 1'b0};
        cnt_s   = cnt_r + 3'd1;
        if (cnt_r == 3'd7) begin
          // second product: (k-2) * f(k-2), accumulated onto the first
          state_s = ST_MUL_B;
          coef_s  = k_r - 8'd2;
          mcand_s = a_r;
        end else begin
          state_s = ST_MUL_A;
        end
      end
      ST_MUL_B: begin
        acc_s   = add_s;
        coef_s  = {1'b0, coef_r[7:1]};
        mcand_s = {mcand_r[WORDSIZE-2:0], 1'b0};
        cnt_s   = cnt_r + 3'd1;
        if (cnt_r == 3'd7) begin
          state_s = ST_UPDATE;
        end else begin
          state_s = ST_MUL_B;
        end
      end
      ST_UPDATE: begin
        a_s   = b_r;
        b_s   = acc_r;
        acc_s = WORD_ZERO;
        if (k_r == arg_r) begin
          state_s = ST_DONE;
        end else begin
          // next term's first coefficient is (k+1)-1 = k, multiplicand is new b
          state_s = ST_MUL_A;
          k_s     = k_r + 8'd1;
          coef_s  = k_r;
          mcand_s = acc_r;
          cnt_s   = 3'd0;
        end
      end
      ST_DONE: begin
        ready_s  = 1'b1;
        result_s = b_r;
      end
      default: begin
        state_s = ST_LOAD;
      end
    endcase
  end

  // State registers; reset restores the seed terms and restarts at LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_LOAD;
      arg_r    <= 8'd0;
      k_r      <= 8'd3;
      coef_r   <= 8'd0;
      cnt_r    <= 3'd0;
      a_r      <= WORD_ONE;
      b_r      <= WORD_ONE;
      acc_r    <= WORD_ZERO;
      mcand_r  <= WORD_ZERO;
      result_r <= WORD_ZERO;
      ready_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      arg_r    <= arg_s;
      k_r      <= k_s;
      coef_r   <= coef_s;
      cnt_r    <= cnt_s;
      a_r      <= a_s;
      b_r      <= b_s;
      acc_r    <= acc_s;
      mcand_r  <= mcand_s;
      result_r <= result_s;
      ready_r  <= ready_s;
    end
  end

endmodule

// File: tb/tb_fib_engine.sv
// Self-checking bench for fib_engine: a 128-bit instance and an 8-bit
// instance run side by side from the same clock, reset and index.
module tb_fib_engine;

  logic         clk;
  logic         rst;
  logic [7:0]   n;
  logic         ready;
  logic [127:0] result;
  logic         ready8;
  logic [7:0]   result8;
  int           checks;
  int           errors;

  fib_engine #(.WORDSIZE(128)) dut (
    .clk(clk), .rst(rst), .n(n), .ready(ready), .result(result)
  );

  fib_engine #(.WORDSIZE(8)) dut8 (
    .clk(clk), .rst(rst), .n(n), .ready(ready8), .result(result8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain iterative recurrence, modulo 2^128.
  function automatic logic [127:0] fib_model(input int nv);
    logic [127:0] fa, fb, fc;
    fa = 128'd1;
    fb = 128'd1;
    if (nv <= 2) return 128'd1;
    for (int k = 3; k <= nv; k++) begin
      fc = 128'(k - 1) * fb + 128'(k - 2) * fa;
      fa = fb;
      fb = fc;
    end
    return fb;
  endfunction

  // Reset (checking that outputs clear at once), release, count cycles to ready.
  task automatic run_case(input logic [7:0] nv);
    int           cyc;
    int           lat;
    bit           leak;
    logic [127:0] exp;
    exp = fib_model(int'(nv));
    lat = (nv <= 8'd2) ? 2 : 17 * (int'(nv) - 2) + 2;
    @(negedge clk);
    rst = 1'b0;
    n   = nv;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 128'd0 || ready8 !== 1'b0 || result8 !== 8'd0) begin
      errors++;
      $display("FAIL reset_clear n=%0d: ready=%0b result=%0d ready8=%0b result8=%0d want 0", nv, ready, result, ready8, result8);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc  = 0;
    leak = 1'b0;
    while (ready !== 1'b1 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      n = 8'($urandom);
      if (ready !== 1'b1 && result !== 128'd0) leak = 1'b1;
    end
    checks++;
    if (cyc !== lat) begin
      errors++;
      $display("FAIL latency n=%0d: got %0d cycles want %0d", nv, cyc, lat);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL result n=%0d: got %0d want %0d", nv, result, exp);
    end
    checks++;
    if (ready8 !== 1'b1 || result8 !== exp[7:0]) begin
      errors++;
      $display("FAIL wrap8 n=%0d: ready8=%0b result8=%0d want 1/%0d", nv, ready8, result8, exp[7:0]);
    end
    checks++;
    if (leak) begin
      errors++;
      $display("FAIL early_result n=%0d: result nonzero while ready low, want 0", nv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    n   = 8'd4;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || result !== 128'd0) begin
      errors++;
      $display("FAIL in_reset: ready=%0b result=%0d want 0/0", ready, result);
    end
  endtask

  task automatic test_basic_hold();
    bit bad;
    run_case(8'd4);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n = 8'($urandom);
      if (ready !== 1'b1 || result !== 128'd11) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold: ready=%0b result=%0d want 1/11", ready, result);
    end
  endtask

  task automatic test_directed();
    run_case(8'd5);
    run_case(8'd6);
    run_case(8'd9);
    run_case(8'd0);
    run_case(8'd1);
    run_case(8'd2);
    run_case(8'd3);
  endtask

  task automatic test_abort();
    @(negedge clk);
    rst = 1'b0;
    n   = 8'd9;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    rst = 1'b0;
    n   = 8'd4;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 128'd0) begin
      errors++;
      $display("FAIL abort_clear: ready=%0b result=%0d want 0/0", ready, result);
    end
    run_case(8'd4);
  endtask

  task automatic test_random();
    run_case(8'd40);
    for (int i = 0; i < 6; i++) begin
      run_case(8'($urandom_range(0, 30)));
    end
    run_case(8'd255);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    n      = 8'd0;
    test_reset();
    test_basic_hold();
    test_directed();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
